// File: rtl/piso_tx_pkg.sv
// Shared types and sizing helpers for the piso_tx serial transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int GAP_CW = 4;

  // Width of a down-counter that must hold DW-1; never narrower than one bit.
  function automatic int cnt_width(input int dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// DW-bit left-shifting register with synchronous load/shift and async clear; output is the MSB.
module piso_shreg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          shift,
  input  logic          fill,
  input  logic [DW-1:0] load_data,
  output logic          msb
);

  logic [DW-1:0] bits;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
    end else if (load) begin
      bits <= load_data;
    end else if (shift) begin
      bits <= {bits[DW-2:0], fill};
    end
  end

  assign msb = bits[DW-1];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter, MSB-first with framing strobes and an idle gap.
// Optional trailing even-parity bit when PISO_TX_PARITY_EN is defined.
module piso_tx
  import piso_pkg::*;
#(
  parameter int DW  = 8,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          q,
  output logic          q_en,
  output logic          q_first,
  output logic          q_last,
  output logic          busy
);

  localparam int                CW       = cnt_width(DW);
  localparam logic [CW-1:0]     CNT_TOP  = CW'(DW - 1);
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [GAP_CW-1:0]   gcnt, gcnt_nxt;
  logic                ready_nxt;
  logic                ld, sh, fill, last_bit;
  logic [DW-1:0]       ld_data;

`ifdef PISO_TX_PARITY_EN
  // par holds the parity of the accepted word; par_phase marks the trailing parity cycle.
  logic par, par_nxt, par_phase, par_phase_nxt;
  assign fill     = par;
  assign last_bit = par_phase;
`else
  assign fill     = 1'b0;
  assign last_bit = (cnt == '0);
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    gcnt_nxt  = gcnt;
    ld        = 1'b0;
    sh        = 1'b0;
    ld_data   = '0;
`ifdef PISO_TX_PARITY_EN
    par_nxt       = par;
    par_phase_nxt = par_phase;
`endif
    case (state)
      S_IDLE: begin
        if (din_valid && din_ready) begin
          state_nxt = S_SHIFT;
          cnt_nxt   = CNT_TOP;
          ld        = 1'b1;
          ld_data   = din;
`ifdef PISO_TX_PARITY_EN
          par_nxt       = ^din;
          par_phase_nxt = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          // Reload zeros so q rests low between frames.
          ld        = 1'b1;
          gcnt_nxt  = '0;
          state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
`ifdef PISO_TX_PARITY_EN
          par_phase_nxt = 1'b0;
`endif
        end else begin
          sh = 1'b1;
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end
`ifdef PISO_TX_PARITY_EN
          else begin
            par_phase_nxt = 1'b1;
          end
`endif
        end
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    ready_nxt = (state_nxt == S_IDLE);
  end

  // NOTE: only control flops carry the async reset; the shift register is cleared inside piso_shreg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gcnt      <= '0;
      din_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gcnt      <= gcnt_nxt;
      din_ready <= ready_nxt;
    end
  end

`ifdef PISO_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par       <= 1'b0;
      par_phase <= 1'b0;
    end else begin
      par       <= par_nxt;
      par_phase <= par_phase_nxt;
    end
  end
`endif

  piso_shreg #(.DW(DW)) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ld),
    .shift     (sh),
    .fill      (fill),
    .load_data (ld_data),
    .msb       (q)
  );

  assign q_en    = (state == S_SHIFT);
  assign q_first = (state == S_SHIFT) && (cnt == CNT_TOP);
  assign q_last  = (state == S_SHIFT) && last_bit;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: per-cycle comparison against a queue-based frame model.
module tb_piso_tx;

  localparam int DW  = 8;
  localparam int GAP = 1;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_valid0 = 1'b0;

  logic din_ready, q, q_en, q_first, q_last, busy;
  logic din_ready0, q0, q_en0, q_first0, q_last0, busy0;

  piso_tx #(.DW(DW), .GAP(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .q(q), .q_en(q_en), .q_first(q_first),
    .q_last(q_last), .busy(busy)
  );

  piso_tx #(.DW(DW), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid0),
    .din_ready(din_ready0), .q(q0), .q_en(q_en0), .q_first(q_first0),
    .q_last(q_last0), .busy(busy0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs of the GAP=1 instance.
  typedef struct packed {
    logic ready;
    logic busy;
    logic q;
    logic en;
    logic first;
    logic last;
  } rec_t;

  localparam rec_t IDLE_REC = 6'b100000;

  rec_t cur = '0;
  rec_t pend[$];

  int cyc = 0;
  int first_prev = -1, first_last = -1;
  int first0_prev = -1, first0_last = -1;
  logic [31:0] cap = '0;

  function automatic rec_t observed();
    rec_t r;
    r = {din_ready, busy, q, q_en, q_first, q_last};
    return r;
  endfunction

  task automatic push_frame(input logic [DW-1:0] w);
    logic [FL-1:0] bits;
    rec_t r;
`ifdef PISO_TX_PARITY_EN
    bits = {w, ^w};
`else
    bits = w;
`endif
    for (int i = 0; i < FL; i++) begin
      r = '0;
      r.busy  = 1'b1;
      r.en    = 1'b1;
      r.q     = bits[FL-1-i];
      r.first = (i == 0);
      r.last  = (i == FL - 1);
      pend.push_back(r);
    end
    for (int g = 0; g < GAP; g++) begin
      r = '0;
      r.busy = 1'b1;
      pend.push_back(r);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      pend.delete();
      cur = '0;
    end else begin
      if (din_valid && cur.ready) push_frame(din);
      if (pend.size() > 0) cur = pend.pop_front();
      else cur = IDLE_REC;
    end
  endtask

  // One clock: model updates at the edge, outputs compared on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag, 32'(observed()), 32'(cur));
    cyc++;
    if (q_first) begin
      first_prev = first_last;
      first_last = cyc;
    end
    if (q_first0) begin
      first0_prev = first0_last;
      first0_last = cyc;
    end
    if (q_en) cap = {cap[30:0], q};
  endtask

  task automatic drain();
    din_valid = 1'b0;
    repeat (FL + GAP + 2) cycle("drain");
  endtask

  task automatic send_capture(input logic [DW-1:0] w, input string tag);
    cap = '0;
    din = w;
    din_valid = 1'b1;
    cycle({tag, "_acc"});
    din_valid = 1'b0;
    repeat (FL - 1) cycle(tag);
    check({tag, "_bits"}, 32'(cap >> (FL - DW)) & 32'hFF, 32'(w));
    check({tag, "_last"}, 32'(q_last), 32'd1);
  endtask

  initial begin
    // Reset hold with din_valid asserted.
    din = 8'h55;
    din_valid = 1'b1;
    #1;
    check("rst_outs", 32'(observed()), 32'd0);
    repeat (3) cycle("rst_hold");
    rst_n = 1'b1;
    cycle("rst_release");
    check("ready_after_release", 32'(din_ready), 32'd1);
    check("no_accept_in_reset", 32'(busy), 32'd0);
    din_valid = 1'b0;
    cycle("idle");

    // Single frame of A5 followed by the gap and a ready idle cycle.
    send_capture(8'hA5, "a5");
    cycle("a5_gap");
    check("a5_gap_busy", 32'({busy, q_en}), 32'b10);
    cycle("a5_ready");
    check("a5_ready", 32'(din_ready), 32'd1);

    // Back-to-back with valid held high.
    din = 8'hFF;
    din_valid = 1'b1;
    cycle("b2b_acc");
    din = 8'h00;
    repeat (FL + GAP + 1) cycle("b2b");
    check("b2b_spacing", 32'(first_last - first_prev), 32'(FL + GAP + 1));
    drain();

    // GAP=0 instance: minimum period is one cycle longer than the frame.
    din = 8'h5A;
    din_valid0 = 1'b1;
    repeat (2 * (FL + 1) + 1) cycle("gap0");
    din_valid0 = 1'b0;
    check("gap0_spacing", 32'(first0_last - first0_prev), 32'(FL + 1));
    drain();

    // Input changes while busy are ignored.
    cap = '0;
    din = 8'hC3;
    din_valid = 1'b1;
    cycle("ign_acc");
    din = 8'h3C;
    repeat (3) cycle("ign");
    din_valid = 1'b0;
    repeat (FL - 4) cycle("ign");
    check("ign_bits", 32'(cap >> (FL - DW)) & 32'hFF, 32'hC3);
    drain();

    // Reset in the middle of a frame, then a clean frame.
    din = 8'hF0;
    din_valid = 1'b1;
    cycle("mid_acc");
    din_valid = 1'b0;
    repeat (3) cycle("mid");
    rst_n = 1'b0;
    #1;
    check("mid_rst_async", 32'(observed()), 32'd0);
    cycle("mid_rst");
    rst_n = 1'b1;
    cycle("mid_release");
    check("mid_no_resume", 32'(busy), 32'd0);
    send_capture(8'h81, "after_rst");
    drain();

`ifdef PISO_TX_PARITY_EN
    send_capture(8'h07, "par07");
    check("par07_bit", 32'(cap[0]), 32'd1);
    drain();
    send_capture(8'h03, "par03");
    check("par03_bit", 32'(cap[0]), 32'd0);
    drain();
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      din = DW'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        cycle("rand_rst");
        rst_n = 1'b1;
      end
      cycle("rand");
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
